// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-bus bridge: FSM states,
// command bytes, response status codes and byte-lane helpers.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_STATUS,
        S_RDATA
    } state_e;

    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_READ   = 8'h52;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_BUSERR  = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT = 8'hE0;

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = b;
        return w;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module uart_bridge_timer #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [Width-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART byte-stream bus initiator: parses W/R command frames, issues one 32-bit
// bus transaction per frame and streams back a status byte plus read data.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int IdleTimeout = 100000,
    parameter int BusTimeout  = 1024,
    parameter int AddrWidth   = 32
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 rx_err,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [AddrWidth-1:0] bus_addr,
    output logic                 bus_wen,
    output logic                 bus_ren,
    output logic [31:0]          bus_wdata,
    output logic [3:0]           bus_strobe,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_request_stall,
    input  logic                 bus_error,
    output logic                 busy
);

    localparam int IdleW = $clog2(IdleTimeout + 1);
    localparam int BusW  = $clog2(BusTimeout + 1);

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  status_q, status_d;
    logic        req_q, req_d;

    logic idle_load, idle_dec, idle_expired;
    logic bus_load, bus_dec, bus_expired;
    logic rx_good;

    uart_bridge_timer #(.Width(IdleW)) u_idle_timer (
        .clk      (clk),
        .nReset   (nReset),
        .load     (idle_load),
        .load_val (IdleW'(IdleTimeout)),
        .dec      (idle_dec),
        .expired  (idle_expired)
    );

    // Loaded one short so the request is dropped after exactly BusTimeout stalled cycles.
    uart_bridge_timer #(.Width(BusW)) u_bus_timer (
        .clk      (clk),
        .nReset   (nReset),
        .load     (bus_load),
        .load_val (BusW'(BusTimeout - 1)),
        .dec      (bus_dec),
        .expired  (bus_expired)
    );

    assign rx_good = rx_done && !rx_err;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        req_d      = req_q;
        idle_load  = 1'b0;
        idle_dec   = 1'b0;
        bus_load   = 1'b0;
        bus_dec    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (rx_good && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    is_write_d = (rx_data == CMD_WRITE);
                    idx_d      = 2'd0;
                    idle_load  = 1'b1;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR, S_WDATA: begin
                idle_dec = 1'b1;
                if (rx_done && rx_err) begin
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end else if (rx_done) begin
                    idle_load = 1'b1;
                    idx_d     = idx_q + 2'd1;
                    if (state_q == S_ADDR) begin
                        addr_d = put_byte(addr_q, idx_q, rx_data);
                    end else begin
                        wdata_d = put_byte(wdata_q, idx_q, rx_data);
                    end
                    if (idx_q == 2'd3) begin
                        if (state_q == S_ADDR && is_write_q) begin
                            state_d = S_WDATA;
                        end else begin
                            req_d    = 1'b1;
                            bus_load = 1'b1;
                            state_d  = S_BUS;
                        end
                    end
                end else if (idle_expired) begin
                    idx_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end

            S_BUS: begin
                bus_dec = bus_request_stall;
                if (!bus_request_stall) begin
                    rdata_d  = bus_rdata;
                    status_d = bus_error ? ST_BUSERR : ST_OK;
                    req_d    = 1'b0;
                    state_d  = S_STATUS;
                end else if (bus_expired) begin
                    status_d = ST_TIMEOUT;
                    req_d    = 1'b0;
                    state_d  = S_STATUS;
                end
            end

            S_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready) begin
                    idx_d   = 2'd0;
                    state_d = (!is_write_q && status_q == ST_OK) ? S_RDATA : S_IDLE;
                end
            end

            S_RDATA: begin
                tx_valid = 1'b1;
                tx_data  = get_byte(rdata_q, idx_q);
                if (tx_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            idx_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            req_q      <= req_d;
        end
    end

    assign bus_addr   = addr_q[AddrWidth-1:0];
    assign bus_wdata  = wdata_q;
    assign bus_wen    = req_q && is_write_q;
    assign bus_ren    = req_q && !is_write_q;
    assign bus_strobe = 4'hF;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: table of frames plus hand-written
// corner sequences, with tx-byte and bus-transaction scoreboards.
module tb_uart_bus_bridge;
    import uart_bridge_pkg::*;

    localparam int IdleTo = 40;
    localparam int BusTo  = 16;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] bus_addr;
    logic        bus_wen;
    logic        bus_ren;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_request_stall = 1'b0;
    logic        bus_error = 1'b0;
    logic        busy;

    uart_bus_bridge #(
        .IdleTimeout (IdleTo),
        .BusTimeout  (BusTo),
        .AddrWidth   (32)
    ) dut (
        .clk               (clk),
        .nReset            (nReset),
        .rx_data           (rx_data),
        .rx_done           (rx_done),
        .rx_err            (rx_err),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .bus_addr          (bus_addr),
        .bus_wen           (bus_wen),
        .bus_ren           (bus_ren),
        .bus_wdata         (bus_wdata),
        .bus_strobe        (bus_strobe),
        .bus_rdata         (bus_rdata),
        .bus_request_stall (bus_request_stall),
        .bus_error         (bus_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall_n;
        bit          stall_hang;
        bit          err;
        logic [7:0]  exp_status;
    } vec_t;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_exp_t;

    logic [7:0] tx_q[$];
    bus_exp_t   bus_q[$];
    vec_t       vecs[6];

    int errors = 0;
    int checks = 0;

    int stall_n       = 0;
    bit stall_forever = 1'b0;
    bit ignore_bus    = 1'b0;
    bit status_due    = 1'b0;
    int req_len       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Bus responder, transmitter sink and both scoreboards, evaluated mid-cycle.
    always @(negedge clk) begin
        bus_exp_t e;
        if (status_due) begin
            status_due = 1'b0;
            check("status_latency", tx_valid, 1'b1);
        end

        tx_ready = ($urandom_range(0, 3) != 0);
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h, want no byte", tx_data);
            end else begin
                check("tx_byte", tx_data, tx_q.pop_front());
            end
        end

        if (bus_wen || bus_ren) begin
            if (req_len == 0 && !ignore_bus) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got addr %h, want no access", bus_addr);
                end else begin
                    e = bus_q[0];
                    check("bus_kind", {bus_wen, bus_ren}, e.is_write ? 2'b10 : 2'b01);
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_strobe", bus_strobe, 4'hF);
                    if (e.is_write) check("bus_wdata", bus_wdata, e.wdata);
                end
            end
            bus_request_stall = stall_forever || (req_len < stall_n);
            req_len++;
            if (!bus_request_stall && !ignore_bus) status_due = 1'b1;
        end else begin
            bus_request_stall = 1'b0;
            if (req_len != 0 && !ignore_bus && bus_q.size() != 0) begin
                e = bus_q.pop_front();
                check("bus_req_len", req_len, e.len);
            end
            req_len = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit err);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        rx_err  = err;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_err  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_frame(input bit is_write, input logic [31:0] addr, input logic [31:0] wdata);
        send_byte(is_write ? CMD_WRITE : CMD_READ, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b0);
        if (is_write) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || tx_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {busy, tx_q.size() != 0, bus_q.size() != 0}, 3'b000);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        stall_n       = v.stall_n;
        stall_forever = v.stall_hang;
        bus_error     = v.err;
        bus_rdata     = v.rdata;
        bus_q.push_back('{is_write: v.is_write, addr: v.addr, wdata: v.wdata,
                          len: v.stall_hang ? BusTo : v.stall_n + 1});
        tx_q.push_back(v.exp_status);
        if (!v.is_write && v.exp_status == ST_OK)
            for (int i = 0; i < 4; i++) tx_q.push_back(v.rdata[8*i +: 8]);
        send_frame(v.is_write, v.addr, v.wdata);
        @(negedge clk);
        check({name, "_req_latency"}, bus_wen || bus_ren, 1'b1);
        check({name, "_busy"}, busy, 1'b1);
        wait_idle(name);
        stall_forever = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{is_write: 1'b1, addr: 32'h8000_0010, wdata: 32'hDEAD_BEEF, rdata: 32'h0,
                    stall_n: 0, stall_hang: 1'b0, err: 1'b0, exp_status: ST_OK};
        vecs[1] = '{is_write: 1'b0, addr: 32'h0000_0004, wdata: 32'h0, rdata: 32'h1234_5678,
                    stall_n: 3, stall_hang: 1'b0, err: 1'b0, exp_status: ST_OK};
        vecs[2] = '{is_write: 1'b0, addr: 32'h0000_0008, wdata: 32'h0, rdata: 32'hCAFE_F00D,
                    stall_n: 1, stall_hang: 1'b0, err: 1'b1, exp_status: ST_BUSERR};
        vecs[3] = '{is_write: 1'b0, addr: 32'h4000_0100, wdata: 32'h0, rdata: 32'h0,
                    stall_n: 0, stall_hang: 1'b1, err: 1'b0, exp_status: ST_TIMEOUT};
        vecs[4] = '{is_write: 1'b1, addr: 32'h1122_3344, wdata: 32'h5566_7788, rdata: 32'h0,
                    stall_n: 2, stall_hang: 1'b0, err: 1'b1, exp_status: ST_BUSERR};
        vecs[5] = '{is_write: 1'b0, addr: 32'hA1B2_C3D4, wdata: 32'h0, rdata: 32'h0BAD_C0DE,
                    stall_n: 0, stall_hang: 1'b0, err: 1'b0, exp_status: ST_OK};

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_req", {bus_wen, bus_ren}, 2'b00);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_strobe", bus_strobe, 4'hF);
        repeat (3) @(negedge clk);
        nReset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Incomplete frame abandoned on silence, then a junk byte is ignored.
        send_byte(CMD_READ, 1'b0);
        send_byte(8'h04, 1'b0);
        repeat (30) @(negedge clk);
        check("idle_pending_busy", busy, 1'b1);
        repeat (15) @(negedge clk);
        check("idle_timeout_busy", busy, 1'b0);
        send_byte(8'h41, 1'b0);
        @(negedge clk);
        check("junk_ignored", busy, 1'b0);

        // Framing error in the middle of the address drops the frame.
        send_byte(CMD_WRITE, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        check("rx_err_abort", busy, 1'b0);
        run_vec(vecs[1], "after_rx_err");

        // Asynchronous reset while a request is stalled on the bus.
        ignore_bus    = 1'b1;
        stall_forever = 1'b1;
        send_frame(1'b0, 32'h0000_0020, 32'h0);
        repeat (3) @(negedge clk);
        check("bus_held", bus_ren, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        check("mid_rst_req", {bus_wen, bus_ren}, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tx", {tx_valid, tx_data}, 9'h000);
        check("mid_rst_addr", bus_addr, 32'h0);
        check("mid_rst_strobe", bus_strobe, 4'hF);
        @(negedge clk);
        nReset        = 1'b1;
        stall_forever = 1'b0;
        repeat (2) @(negedge clk);
        ignore_bus    = 1'b0;
        run_vec(vecs[0], "after_reset");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- UART-side bus initiator: parses byte-serial command frames from the UART receiver path and issues single 32-bit read/write transactions on the SoC bus.
- Returns status, plus read data, as a byte stream to the UART transmitter path.
- Counterpart to the AHB UART peripheral: external hosts (debugger, test PC) gain bus-master access through a UART link.
- Sits between UartRxEn/UartTxEn-style byte engines and the bus_protocol_if initiator side.

Parameters:
- IdleTimeout, 100000, clocks without a new rx byte before an incomplete frame is abandoned (counter width $clog2(IdleTimeout+1))
- BusTimeout, 1024, clocks of continuous bus_request_stall before a transaction is aborted
- AddrWidth, 32, bus address width (frame always carries 4 address bytes; upper bytes truncated)

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_done  in  1  one-cycle pulse, rx_data valid
- rx_err  in  1  framing error accompanying rx_done
- tx_data  out  8  byte to transmit
- tx_valid  out  1  byte offered to transmitter
- tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
- bus_addr  out  AddrWidth  transaction address
- bus_wen  out  1  write request
- bus_ren  out  1  read request
- bus_wdata  out  32  write data
- bus_strobe  out  4  byte enables, always 4'hF
- bus_rdata  in  32  read data
- bus_request_stall  in  1  responder not ready; hold request
- bus_error  in  1  responder error, sampled on completion
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset asynchronous, active-low. Reset: state IDLE; all outputs 0 except bus_strobe = 4'hF; counters 0; shift registers 0.
- Frame format, all fields LSB first:
  - CMD: 8'h57 'W' or 8'h52 'R'
  - ADDR: 4 bytes
  - WDATA: 4 bytes, W only
- Response format:
  - STATUS: 8'hA5 ok, 8'hEE bus error, 8'hE0 bus timeout
  - RDATA: 4 bytes, R with ok only
- FSM states: IDLE, ADDR, WDATA, BUS, STATUS, RDATA.
- IDLE:
  - rx_done && !rx_err && byte is 'W' or 'R' -> latch cmd, ADDR.
  - Any other byte, or rx_err, is discarded silently.
- ADDR / WDATA:
  - Each good rx_done shifts the byte into a 2-bit-indexed register; after the 4th byte go to WDATA (W) or BUS (R/after WDATA).
  - rx_done with rx_err -> IDLE, no response.
  - Idle counter resets on every rx_done; reaching IdleTimeout -> IDLE, no response.
- BUS:
  - The cycle after entry, assert bus_wen or bus_ren with addr/wdata stable; hold all while bus_request_stall = 1.
  - Completion = first cycle with the request asserted and stall = 0. In that cycle, capture bus_rdata and bus_error, deassert the request the next cycle, go to STATUS.
  - Stall counter reaching BusTimeout -> drop the request, status 8'hE0.
  - Exactly one wen/ren pulse-train per frame; wen and ren never both high.
- STATUS: tx_valid = 1 with the status byte until tx_ready; then go to RDATA if R and ok, else IDLE.
- RDATA: 4 bytes LSB first, each held until accepted; IDLE after the 4th.
- rx bytes arriving in BUS/STATUS/RDATA are dropped (half-duplex protocol); the host waits for the response.
- tx_data is don't-care when tx_valid = 0, but is driven 0.
- Latency: bus request asserted 1 clk after the last frame byte's rx_done; STATUS offered 1 clk after completion.

Decomposition:
- Shared package uart_bridge_pkg:
  - state enum
  - command constants CMD_WRITE/CMD_READ
  - status constants ST_OK/ST_BUSERR/ST_TIMEOUT
- One natural sub-module: uart_bridge_timer, a loadable saturating down-counter reused for the idle and bus timeouts. The FSM, shifters and bus driver stay in the top.

Test Plan:
- Write: rx 57 10 00 00 80 EF BE AD DE -> one write: bus_addr = 32'h8000_0010, bus_wdata = 32'hDEADBEEF, strobe F; tx A5; busy falls after tx accepted.
- Read with 3-cycle stall: rx 52 04 00 00 00, bus_rdata = 32'h1234_5678 -> ren held 4 clks; tx A5 78 56 34 12.
- Bus error: read with bus_error = 1 at completion -> tx EE only, no data bytes.
- Bus timeout: BusTimeout = 16, stall stuck high -> ren drops after 16 clks; tx E0; FSM IDLE.
- Idle timeout and junk: rx 52 04 then silence for IdleTimeout clks -> IDLE, no tx, no bus access; a following 41 byte is ignored.
- rx_err mid-address, and nReset asserted during BUS -> immediate IDLE, outputs zero, a subsequent valid frame completes normally.
